// File: rtl/wb_pkg.sv
// Shared encodings and types for the writeback stage and its load-alignment helper.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [1:0] LS_BYTE = 2'd0;
    localparam logic [1:0] LS_HALF = 2'd1;
    localparam logic [1:0] LS_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_COMMIT   = 2'd2
    } wb_state_e;

    // Fields of a load parked while its read data is outstanding.
    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic              reg_write;
        logic [1:0]        load_size;
        logic              load_signed;
        logic [1:0]        addr_lo;
    } held_load_t;

    // Reserved select value 3 falls back to the ALU result.
    function automatic logic [XLEN-1:0] select_result(input logic [1:0] sel,
                                                      input logic [XLEN-1:0] alu,
                                                      input logic [XLEN-1:0] link);
        case (sel)
            WB_ALU:  return alu;
            WB_LINK: return link;
            default: return alu;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational little-endian lane extraction and sign/zero extension for loads,
// with a misalignment flag for half/word accesses.
module load_align
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data       = rdata;
        misaligned = 1'b0;
        case (size)
            LS_BYTE: data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            LS_HALF: begin
                data       = {{16{sign_ext & half_lane[15]}}, half_lane};
                misaligned = addr_lo[0];
            end
            LS_WORD: misaligned = (addr_lo != 2'b00);
            default: misaligned = (addr_lo != 2'b00);
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects ALU/load/link data and drives the register file write port.
// Optional WB_BYPASS_EN adds a same-cycle write-before-read forwarding path.
module writeback_stage
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_reg_write,
    input  logic [1:0]        in_wb_sel,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_pc_plus4,
    input  logic [1:0]        in_load_size,
    input  logic              in_load_signed,
    input  logic [1:0]        in_addr_lo,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rvalid,
    input  logic              flush,
    output logic              RegWrite,
    output logic [REG_AW-1:0] WriteReg,
    output logic [XLEN-1:0]   WriteData,
    output logic              retire,
    output logic              misalign_err,
`ifdef WB_BYPASS_EN
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    input  logic [XLEN-1:0]   rf_data1,
    input  logic [XLEN-1:0]   rf_data2,
    output logic [XLEN-1:0]   data1_fwd,
    output logic [XLEN-1:0]   data2_fwd,
`endif
    output logic [1:0]        dbg_state
);

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid.

    wb_state_e         state, state_nx;
    held_load_t        held, held_nx;
    logic              reg_write_nx, retire_nx, misalign_nx;
    logic [REG_AW-1:0] wreg_nx;
    logic [XLEN-1:0]   wdata_nx;
    logic [XLEN-1:0]   ld_data;
    logic              ld_mis;
    logic              accept;

    assign in_ready  = (state == ST_IDLE) || (state == ST_COMMIT);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    load_align u_load_align (
        .rdata      (mem_rdata),
        .addr_lo    (held.addr_lo),
        .size       (held.load_size),
        .sign_ext   (held.load_signed),
        .data       (ld_data),
        .misaligned (ld_mis)
    );

    always_comb begin
        state_nx     = state;
        held_nx      = held;
        reg_write_nx = 1'b0;
        retire_nx    = 1'b0;
        misalign_nx  = 1'b0;
        wreg_nx      = WriteReg;
        wdata_nx     = WriteData;

        if (flush) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_COMMIT: begin
                    state_nx = ST_IDLE;
                    if (accept) begin
                        if (in_wb_sel == WB_LOAD) begin
                            held_nx  = '{dest: in_dest, reg_write: in_reg_write,
                                         load_size: in_load_size,
                                         load_signed: in_load_signed,
                                         addr_lo: in_addr_lo};
                            state_nx = ST_WAIT_MEM;
                        end else begin
                            state_nx     = ST_COMMIT;
                            retire_nx    = 1'b1;
                            reg_write_nx = in_reg_write && (in_dest != '0);
                            wreg_nx      = in_dest;
                            wdata_nx     = select_result(in_wb_sel, in_alu_result, in_pc_plus4);
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        state_nx     = ST_COMMIT;
                        retire_nx    = 1'b1;
                        misalign_nx  = ld_mis;
                        reg_write_nx = held.reg_write && (held.dest != '0) && !ld_mis;
                        wreg_nx      = held.dest;
                        // A misaligned load still commits, exposing the raw word for diagnosis.
                        wdata_nx     = ld_mis ? mem_rdata : ld_data;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            held         <= '0;
            RegWrite     <= 1'b0;
            WriteReg     <= '0;
            WriteData    <= '0;
            retire       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nx;
            held         <= held_nx;
            RegWrite     <= reg_write_nx;
            WriteReg     <= wreg_nx;
            WriteData    <= wdata_nx;
            retire       <= retire_nx;
            misalign_err <= misalign_nx;
        end
    end

`ifdef WB_BYPASS_EN
    assign data1_fwd = (RegWrite && (WriteReg == rd_addr1)) ? WriteData : rf_data1;
    assign data2_fwd = (RegWrite && (WriteReg == rd_addr2)) ? WriteData : rf_data2;
`endif

endmodule
